// File: rtl/i2s_adc_rx_if.sv
// i2s_adc_rx output bundle: captured word, channel tag
// and valid/ready handshake in the mclk domain.
interface i2s_adc_rx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] out_data;
  logic             out_chan;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_chan,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_chan,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: oversampled codec ADC deserializer, MSB first.
// Optional I2S_DELAY_EN: one-bclk delay (standard I2S framing).
module i2s_adc_rx #(
  parameter int WIDTH      = 16,
  parameter int ARM_CYCLES = 4
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             bclk,
  input  logic             adclrc,
  input  logic             adcdat,
  i2s_adc_rx_if.master     bus,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(ARM_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef I2S_DELAY_EN
    SKIP  = 2'd3,
`endif
    HOLD  = 2'd2
  } state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrc_s1_q, lrc_s2_q, lrc_s3_q;
  logic dat_s1_q, dat_s2_q;

  logic [AW-1:0] arm_q;
  logic          armed;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic            chan_q, chan_d;
  logic            complete;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] data_q;
  logic            ochan_q;
  logic            valid_q;
  logic            ovr_q;

  logic bit_rise;
  logic lrc_edge;

  assign bit_rise = bclk_s2_q & ~bclk_s3_q;
  assign lrc_edge = lrc_s2_q ^ lrc_s3_q;
  assign armed    = (arm_q == AW'(ARM_CYCLES));
  assign word     = {sreg_q[WIDTH-2:0], dat_s2_q};

  // Bring the codec signals into mclk, extra stage for edges
  always_ff @(posedge mclk) begin
    if (!rst) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      lrc_s1_q  <= 1'b0;
      lrc_s2_q  <= 1'b0;
      lrc_s3_q  <= 1'b0;
      dat_s1_q  <= 1'b0;
      dat_s2_q  <= 1'b0;
    end else begin
      bclk_s1_q <= bclk;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      lrc_s1_q  <= adclrc;
      lrc_s2_q  <= lrc_s1_q;
      lrc_s3_q  <= lrc_s2_q;
      dat_s1_q  <= adcdat;
      dat_s2_q  <= dat_s1_q;
    end
  end

  // Hold off frame edges until the synchronizers have settled
  always_ff @(posedge mclk) begin
    if (!rst)
      arm_q <= '0;
    else if (!armed)
      arm_q <= arm_q + AW'(1);
  end

  // Capture FSM and shift register state
  always_ff @(posedge mclk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      chan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      chan_q  <= chan_d;
    end
  end

  // Next state: a frame edge always restarts and eats any bit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    chan_d   = chan_q;
    complete = 1'b0;
    if (lrc_edge && armed) begin
      chan_d = lrc_s2_q;
      cnt_d  = '0;
`ifdef I2S_DELAY_EN
      state_d = SKIP;
`else
      state_d = SHIFT;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
`ifdef I2S_DELAY_EN
        SKIP: begin
          if (bit_rise)
            state_d = SHIFT;
        end
`endif
        SHIFT: begin
          if (bit_rise) begin
            sreg_d = word;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              complete = 1'b1;
              state_d  = HOLD;
            end
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output holding register with sticky overwrite flag
  always_ff @(posedge mclk) begin
    if (!rst) begin
      data_q  <= '0;
      ochan_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (complete) begin
      data_q  <= word;
      ochan_q <= chan_q;
      valid_q <= 1'b1;
      if (valid_q && !bus.out_ready)
        ovr_q <= 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = ochan_q;
  assign bus.out_valid = valid_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: frame table plus corner sequences,
// delivered words checked against an expected-word queue.
module tb_i2s_adc_rx;

`ifdef I2S_DELAY_EN
  localparam int LEAD = 1;
  localparam logic [15:0] DLY_EXP = 16'h8001;
`else
  localparam int LEAD = 0;
  localparam logic [15:0] DLY_EXP = 16'hC000;
`endif

  logic mclk = 1'b0;
  logic rst, bclk, adclrc, adcdat;
  logic overrun;

  i2s_adc_rx_if #(.WIDTH(16)) bus ();

  i2s_adc_rx #(
    .WIDTH(16),
    .ARM_CYCLES(4)
  ) dut (
    .mclk(mclk),
    .rst(rst),
    .bclk(bclk),
    .adclrc(adclrc),
    .adcdat(adcdat),
    .bus(bus),
    .overrun(overrun)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic        chan;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        lrc;
    logic [31:0] word;
    int          n;
    bit          push;
    logic [15:0] exp;
  } vec_t;

  exp_t q[$];
  vec_t tbl[6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_acc    = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic bit_out(input logic b, input logic lrc);
    bclk   = 1'b0;
    adclrc = lrc;
    adcdat = b;
    tick(4);
    bclk = 1'b1;
    tick(4);
  endtask

  task automatic frame(input logic lrc,
                       input logic [31:0] w,
                       input int n,
                       input int lead);
    for (int i = 0; i < lead; i++)
      bit_out(1'b0, lrc);
    for (int i = 0; i < n; i++)
      bit_out(w[n-1-i], lrc);
  endtask

  task automatic push(input logic c, input logic [15:0] d);
    exp_t e;
    e.chan = c;
    e.data = d;
    q.push_back(e);
    n_push++;
  endtask

  // Scoreboard: every accepted word must match the queue head
  always @(negedge mclk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      n_acc++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word actual=%h required=none",
                 bus.out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("word_data", 32'(bus.out_data), 32'(e.data));
        check("word_chan", 32'(bus.out_chan), 32'(e.chan));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 32'hA5C3, 16, 1'b1, 16'hA5C3};
    tbl[1] = '{1'b1, 32'h1234, 16, 1'b1, 16'h1234};
    tbl[2] = '{1'b0, 32'h8001, 16, 1'b1, 16'h8001};
    tbl[3] = '{1'b1, 32'h00FF, 8,  1'b0, 16'h0000};
    tbl[4] = '{1'b0, 32'h0F0F, 16, 1'b1, 16'h0F0F};
    tbl[5] = '{1'b1, 32'h5A5A, 16, 1'b1, 16'h5A5A};

    rst           = 1'b0;
    bclk          = 1'b0;
    adclrc        = 1'b1;
    adcdat        = 1'b0;
    bus.out_ready = 1'b1;
    tick(4);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data",  32'(bus.out_data),  0);
    check("rst_chan",  32'(bus.out_chan),  0);
    check("rst_ovr",   32'(overrun),       0);
    rst = 1'b1;
    tick(8);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].push)
        push(tbl[i].lrc, tbl[i].exp);
      frame(tbl[i].lrc, tbl[i].word, tbl[i].n, LEAD);
    end
    tick(4);
    check("ovr_clear", 32'(overrun), 0);

    bus.out_ready = 1'b0;
    frame(1'b0, 32'h1111, 16, LEAD);
    frame(1'b1, 32'h2222, 16, LEAD);
    tick(4);
    check("bp_valid", 32'(bus.out_valid), 1);
    check("bp_data",  32'(bus.out_data),  32'h2222);
    check("bp_chan",  32'(bus.out_chan),  1);
    check("bp_ovr",   32'(overrun),       1);
    push(1'b1, 16'h2222);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    tick(1);
    check("bp_drain", 32'(bus.out_valid), 0);
    check("bp_stick", 32'(overrun),       1);
    bus.out_ready = 1'b1;

    frame(1'b0, 32'h5555 >> 11, 5, LEAD);
    rst = 1'b0;
    tick(2);
    check("mid_valid", 32'(bus.out_valid), 0);
    check("mid_data",  32'(bus.out_data),  0);
    check("mid_chan",  32'(bus.out_chan),  0);
    check("mid_ovr",   32'(overrun),       0);
    rst = 1'b1;
    tick(8);
    push(1'b1, 16'h3C3C);
    frame(1'b1, 32'h3C3C, 16, LEAD);
    tick(4);

    push(1'b0, DLY_EXP);
    frame(1'b0, 32'h18001, 17, 0);
    tick(4);

    push(1'b1, 16'h00FF);
    bclk   = 1'b0;
    adcdat = 1'b1;
    tick(4);
    adclrc = 1'b1;
    bclk   = 1'b1;
    tick(4);
    frame(1'b1, 32'h00FF, 16, LEAD);
    tick(12);

    check("queue_empty", 32'(q.size()), 0);
    check("word_count",  32'(n_acc),    32'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
